// File: rtl/ram_stream_reader.sv
// ram_stream_reader
//
// Sequential read engine for a small single-port RAM with a registered write
// and a combinational read. On a start command it takes ownership of the RAM
// address and walks a contiguous range, wrapping modulo the RAM depth. Each
// word is presented on a valid/ready output stream.
//
// Ports:
//   clock       rising-edge clock, shared with the RAM
//   reset_n     asynchronous active-low reset
//   start       burst request, only honoured while idle
//   start_addr  first RAM address of the burst
//   length      word count (0 = empty burst, clamps at the RAM depth)
//   abort       synchronous burst cancel, no done pulse
//   mem_addr    registered address driven to the RAM
//   mem_rdata   RAM read data, combinational on mem_addr
//   out_data    stream data
//   out_valid   stream valid
//   out_ready   stream ready
//   busy        high while a burst is in progress
//   done        one-cycle pulse when a burst completes normally

module ram_stream_reader #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH:0]   length,
    input  logic                  abort,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN
    } state_t;

    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    state_t state;
    state_t state_next;

    logic [ADDR_WIDTH:0] remaining;
    logic [ADDR_WIDTH:0] length_clamped;
    logic                xfer;
    logic                load_word;

    // Any length with the top bit set is at least the full depth; a longer
    // burst would only revisit the same words, so it is cut to one lap.
    assign length_clamped = length[ADDR_WIDTH] ? DEPTH : length;

    assign xfer = out_valid && out_ready;

    // A new word may be fetched whenever the output register is empty or is
    // being emptied this edge; abort suppresses the fetch entirely.
    assign load_word = (state == READ) && !abort && (!out_valid || out_ready);

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start && (length != '0)) begin
                    state_next = READ;
                end
            end
            READ: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (load_word && (remaining == (ADDR_WIDTH+1)'(1))) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (abort || xfer) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs that depend only on the state.
    always_comb begin
        busy = 1'b0;
        if (state != IDLE) begin
            busy = 1'b1;
        end
    end

    // Address, word counter and output stream registers. The output register
    // is only rewritten when it is empty or its word is being accepted, which
    // keeps out_data stable under back-pressure.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mem_addr  <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            remaining <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (length == '0) begin
                            done <= 1'b1;
                        end else begin
                            mem_addr  <= start_addr;
                            remaining <= length_clamped;
                        end
                    end
                end
                READ: begin
                    if (abort) begin
                        out_valid <= 1'b0;
                        remaining <= '0;
                    end else if (load_word) begin
                        out_data  <= mem_rdata;
                        out_valid <= 1'b1;
                        mem_addr  <= mem_addr + ADDR_WIDTH'(1);
                        remaining <= remaining - (ADDR_WIDTH+1)'(1);
                    end
                end
                DRAIN: begin
                    if (abort) begin
                        out_valid <= 1'b0;
                        remaining <= '0;
                    end else if (xfer) begin
                        out_valid <= 1'b0;
                        done      <= 1'b1;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    remaining <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_stream_reader.sv
// tb_ram_stream_reader
//
// Directed bench for ram_stream_reader. A behavioural 64x16 RAM preloaded
// with mem[i] = 16'h1000 + i sits on the address/data ports. Expected words,
// cycle counts and final addresses are hand-derived from the burst
// parameters.

module tb_ram_stream_reader;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic [5:0]  start_addr;
    logic [6:0]  length;
    logic        abort;
    logic [5:0]  mem_addr;
    logic [15:0] mem_rdata;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;

    logic [15:0] mem [0:63];

    int check_count;
    int pass_count;
    int fail_count;

    logic [15:0] got_words[$];
    int          burst_cycles;
    int          done_cnt;
    int          overlap_cnt;

    ram_stream_reader #(
        .ADDR_WIDTH(6),
        .DATA_WIDTH(16)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .start_addr(start_addr),
        .length    (length),
        .abort     (abort),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    // Combinational RAM read.
    assign mem_rdata = mem[mem_addr];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Advance to the sample point just after the next rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Pulse start for one edge; returns at the sample point after that edge.
    task automatic applyStimulus(input logic [5:0] addr, input logic [6:0] len);
        start_addr = addr;
        length     = len;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    // Drive out_ready from a pattern (1 once the pattern is exhausted),
    // capture accepted words and watch done until busy falls.
    task automatic runBurst(input logic [15:0] ready_pat, input int pat_len, input int max_cycles);
        logic        held;
        logic [15:0] held_data;
        got_words.delete();
        burst_cycles = 0;
        done_cnt     = 0;
        overlap_cnt  = 0;
        for (int c = 0; c < max_cycles; c++) begin
            out_ready = (c < pat_len) ? ready_pat[c] : 1'b1;
            held      = out_valid && !out_ready;
            held_data = out_data;
            if (out_valid && out_ready) begin
                got_words.push_back(out_data);
            end
            tick();
            burst_cycles++;
            if (held) begin
                checkOutput("hold_data", {16'h0, out_data}, {16'h0, held_data});
                checkOutput("hold_valid", {31'h0, out_valid}, 32'h1);
            end
            if (done) begin
                done_cnt++;
                if (busy) begin
                    overlap_cnt++;
                end
            end
            if (!busy) begin
                break;
            end
        end
        checkOutput("idle_after_burst", {31'h0, busy}, 32'h0);
    endtask

    task automatic checkBurst(input string tag, input int first, input int n, input int exp_cycles, input int exp_addr);
        logic [15:0] w;
        checkOutput({tag, "_count"}, got_words.size(), n);
        for (int i = 0; i < n; i++) begin
            w = (i < got_words.size()) ? got_words[i] : 16'hDEAD;
            checkOutput($sformatf("%s_word%0d", tag, i), {16'h0, w}, 32'h1000 + ((first + i) % 64));
        end
        checkOutput({tag, "_done_pulses"}, done_cnt, 1);
        checkOutput({tag, "_done_busy_overlap"}, overlap_cnt, 0);
        checkOutput({tag, "_cycles"}, burst_cycles, exp_cycles);
        checkOutput({tag, "_final_addr"}, {26'h0, mem_addr}, exp_addr);
    endtask

    initial begin
        check_count = 0;
        pass_count  = 0;
        fail_count  = 0;
        for (int i = 0; i < 64; i++) begin
            mem[i] = 16'h1000 + 16'(i);
        end
        reset_n    = 1'b0;
        start      = 1'b0;
        start_addr = '0;
        length     = '0;
        abort      = 1'b0;
        out_ready  = 1'b1;

        #12;
        checkOutput("rst_valid", {31'h0, out_valid}, 32'h0);
        checkOutput("rst_busy", {31'h0, busy}, 32'h0);
        checkOutput("rst_done", {31'h0, done}, 32'h0);
        checkOutput("rst_addr", {26'h0, mem_addr}, 32'h0);
        checkOutput("rst_data", {16'h0, out_data}, 32'h0);
        reset_n = 1'b1;
        tick();

        $display("[TB] basic burst 5/4");
        applyStimulus(6'd5, 7'd4);
        checkOutput("b1_busy_e0", {31'h0, busy}, 32'h1);
        checkOutput("b1_valid_e0", {31'h0, out_valid}, 32'h0);
        checkOutput("b1_addr_e0", {26'h0, mem_addr}, 32'd5);
        runBurst(16'hFFFF, 0, 20);
        checkBurst("b1", 5, 4, 5, 9);
        tick();
        checkOutput("b1_done_cleared", {31'h0, done}, 32'h0);

        $display("[TB] wrapping burst 62/4");
        applyStimulus(6'd62, 7'd4);
        runBurst(16'hFFFF, 0, 20);
        checkBurst("wrap", 62, 4, 5, 2);

        $display("[TB] back-pressure burst 5/3");
        applyStimulus(6'd5, 7'd3);
        // ready per cycle: 1,0,0,1,0,1 (bit 0 first)
        runBurst(16'b101001, 6, 30);
        checkBurst("bp", 5, 3, 7, 8);

        $display("[TB] empty burst");
        out_ready = 1'b1;
        applyStimulus(6'd20, 7'd0);
        checkOutput("empty_done", {31'h0, done}, 32'h1);
        checkOutput("empty_busy", {31'h0, busy}, 32'h0);
        checkOutput("empty_valid", {31'h0, out_valid}, 32'h0);
        checkOutput("empty_addr", {26'h0, mem_addr}, 32'd8);
        tick();
        checkOutput("empty_done_once", {31'h0, done}, 32'h0);
        checkOutput("empty_valid_after", {31'h0, out_valid}, 32'h0);
        checkOutput("empty_busy_after", {31'h0, busy}, 32'h0);

        $display("[TB] clamped burst 10/100");
        applyStimulus(6'd10, 7'd100);
        runBurst(16'hFFFF, 0, 100);
        checkBurst("clamp", 10, 64, 65, 10);

        $display("[TB] abort on second transfer");
        out_ready = 1'b1;
        applyStimulus(6'd20, 7'd8);
        tick();
        checkOutput("ab_word0", {16'h0, out_data}, 32'h1014);
        tick();
        checkOutput("ab_word1", {16'h0, out_data}, 32'h1015);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("ab_valid", {31'h0, out_valid}, 32'h0);
        checkOutput("ab_busy", {31'h0, busy}, 32'h0);
        checkOutput("ab_done", {31'h0, done}, 32'h0);
        applyStimulus(6'd30, 7'd1);
        checkOutput("ab_restart_busy", {31'h0, busy}, 32'h1);
        runBurst(16'hFFFF, 0, 20);
        checkBurst("ab_restart", 30, 1, 2, 31);

        $display("[TB] async reset mid-burst");
        applyStimulus(6'd40, 7'd8);
        tick();
        tick();
        checkOutput("mr_valid_before", {31'h0, out_valid}, 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("mr_valid", {31'h0, out_valid}, 32'h0);
        checkOutput("mr_busy", {31'h0, busy}, 32'h0);
        checkOutput("mr_addr", {26'h0, mem_addr}, 32'h0);
        checkOutput("mr_data", {16'h0, out_data}, 32'h0);
        checkOutput("mr_done", {31'h0, done}, 32'h0);
        #2;
        reset_n = 1'b1;
        tick();
        applyStimulus(6'd3, 7'd2);
        runBurst(16'hFFFF, 0, 20);
        checkBurst("mr_after", 3, 2, 3, 5);

        $display("[TB] %0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
